// File: rtl/pipe_ctrl_regs.sv
// ============================================================================
//  Module   : pipe_ctrl_regs
//  Purpose  : Front-end pipeline register bank for a 5-stage RV32I core.
//             Holds the PC register, the IF/ID register and the ID/EX
//             register, obeys the hazard unit's stall/flush controls, and
//             exposes the decode/execute register fields the hazard unit
//             compares. Also keeps saturating stall and redirect-flush
//             event counters for performance debug.
//  Ports    :
//    i_clk, i_rst            clock, asynchronous active-high reset
//    i_pcr_StallF/StallD     hold PC / hold IF/ID
//    i_pcr_FlashD/FlashE     clear IF/ID / ID/EX to a bubble
//    i_pcr_PCSrcE            redirect from execute, target i_pcr_PCTargetE
//    i_pcr_InstrF            instruction word fetched at o_pcr_PCF
//    i_pcr_RegWriteD         decode control: register write
//    i_pcr_ResultSrcD0       decode control: load result select
//    i_pcr_CntClr            synchronous clear of both event counters
//    o_pcr_PCF               fetch PC
//    o_pcr_InstrD/PCD/...    IF/ID contents and decoded register fields
//    o_pcr_Rs1E/.../ValidE   ID/EX contents
//    o_pcr_StallCnt/FlushCnt saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_regs #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pcr_StallF,
  input  logic             i_pcr_StallD,
  input  logic             i_pcr_FlashD,
  input  logic             i_pcr_FlashE,
  input  logic             i_pcr_PCSrcE,
  input  logic [XLEN-1:0]  i_pcr_PCTargetE,
  input  logic [31:0]      i_pcr_InstrF,
  input  logic             i_pcr_RegWriteD,
  input  logic             i_pcr_ResultSrcD0,
  input  logic             i_pcr_CntClr,
  output logic [XLEN-1:0]  o_pcr_PCF,
  output logic [31:0]      o_pcr_InstrD,
  output logic [XLEN-1:0]  o_pcr_PCD,
  output logic [XLEN-1:0]  o_pcr_PCPlus4D,
  output logic             o_pcr_ValidD,
  output logic [4:0]       o_pcr_Rs1D,
  output logic [4:0]       o_pcr_Rs2D,
  output logic [4:0]       o_pcr_RdD,
  output logic [4:0]       o_pcr_Rs1E,
  output logic [4:0]       o_pcr_Rs2E,
  output logic [4:0]       o_pcr_RdE,
  output logic [XLEN-1:0]  o_pcr_PCE,
  output logic             o_pcr_ValidE,
  output logic             o_pcr_RegWriteE,
  output logic             o_pcr_ResultSrcE0,
  output logic [CNT_W-1:0] o_pcr_StallCnt,
  output logic [CNT_W-1:0] o_pcr_FlushCnt
);

  // addi x0,x0,0 : its rs1/rs2/rd fields are all zero, so a decode bubble
  // never matches a real register in the hazard comparisons.
  localparam logic [31:0]      c_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_pcf;
  logic [31:0]      r_instr_d;
  logic [XLEN-1:0]  r_pc_d;
  logic             r_valid_d;
  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;
  logic [XLEN-1:0]  r_pc_e;
  logic             r_valid_e;
  logic             r_regwrite_e;
  logic             r_resultsrc_e0;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [4:0]       w_rs1_d;
  logic [4:0]       w_rs2_d;
  logic [4:0]       w_rd_d;

  // Decode fields are taken straight from the IF/ID contents.
  assign w_rs1_d = r_instr_d[19:15];
  assign w_rs2_d = r_instr_d[24:20];
  assign w_rd_d  = r_instr_d[11:7];

  // --------------------------------------------------------------------------
  // PC register: a redirect from execute overrides a fetch stall, since the
  // stalled instruction is on the wrong path anyway.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcf <= RESET_PC;
    end else if (i_pcr_PCSrcE) begin
      r_pcf <= i_pcr_PCTargetE;
    end else if (!i_pcr_StallF) begin
      r_pcf <= r_pcf + c_PC_STEP;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID register: flush beats stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr_d <= c_NOP;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (i_pcr_FlashD) begin
      r_instr_d <= c_NOP;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (!i_pcr_StallD) begin
      r_instr_d <= i_pcr_InstrF;
      r_pc_d    <= r_pcf;
      r_valid_d <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX register: no hold path. During a load-use stall the hazard unit
  // flushes this stage, and the instruction held in IF/ID is captured again
  // on the next unstalled cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_pc_e         <= '0;
      r_valid_e      <= 1'b0;
      r_regwrite_e   <= 1'b0;
      r_resultsrc_e0 <= 1'b0;
    end else if (i_pcr_FlashE) begin
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_pc_e         <= '0;
      r_valid_e      <= 1'b0;
      r_regwrite_e   <= 1'b0;
      r_resultsrc_e0 <= 1'b0;
    end else begin
      r_rs1_e        <= w_rs1_d;
      r_rs2_e        <= w_rs2_d;
      r_rd_e         <= w_rd_d;
      r_pc_e         <= r_pc_d;
      r_valid_e      <= r_valid_d;
      r_regwrite_e   <= i_pcr_RegWriteD;
      r_resultsrc_e0 <= i_pcr_ResultSrcD0;
    end
  end

  // --------------------------------------------------------------------------
  // Event counters. A stall cycle that coincides with a redirect is counted
  // as a flush only, because the redirect is what actually moves the PC.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_pcr_CntClr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_pcr_StallF && !i_pcr_PCSrcE && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (i_pcr_PCSrcE && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_pcr_PCF         = r_pcf;
  assign o_pcr_InstrD      = r_instr_d;
  assign o_pcr_PCD         = r_pc_d;
  assign o_pcr_PCPlus4D    = r_pc_d + c_PC_STEP;
  assign o_pcr_ValidD      = r_valid_d;
  assign o_pcr_Rs1D        = w_rs1_d;
  assign o_pcr_Rs2D        = w_rs2_d;
  assign o_pcr_RdD         = w_rd_d;
  assign o_pcr_Rs1E        = r_rs1_e;
  assign o_pcr_Rs2E        = r_rs2_e;
  assign o_pcr_RdE         = r_rd_e;
  assign o_pcr_PCE         = r_pc_e;
  assign o_pcr_ValidE      = r_valid_e;
  assign o_pcr_RegWriteE   = r_regwrite_e;
  assign o_pcr_ResultSrcE0 = r_resultsrc_e0;
  assign o_pcr_StallCnt    = r_stall_cnt;
  assign o_pcr_FlushCnt    = r_flush_cnt;

endmodule

`default_nettype wire
